// File: rtl/rotate100_realign.sv
// 100-bit rotate register that tracks net rotation offset and can walk back to load alignment.
// Latency: load/rotate visible next cycle; realign takes min(offset,100-offset)+1 edges from align.
// No backpressure: align is sampled only in IDLE, load aborts a realign, ena is ignored while busy.
module rotate100_realign (
  input  logic        clk,
  input  logic        areset_n,
  input  logic        load,
  input  logic [1:0]  ena,
  input  logic [99:0] data,
  input  logic        align,
  output logic [99:0] q,
  output logic [6:0]  offset,
  output logic        busy,
  output logic        done
);

  typedef enum logic {
    IDLE  = 1'b0,
    ALIGN = 1'b1
  } state_t;

  state_t state;

  function automatic logic [99:0] rot_right(input logic [99:0] v);
    return {v[0], v[99:1]};
  endfunction

  function automatic logic [99:0] rot_left(input logic [99:0] v);
    return {v[98:0], v[99]};
  endfunction

  // Offset counts net right steps, so it wraps inside 0..99.
  function automatic logic [6:0] off_inc(input logic [6:0] o);
    return (o == 7'd99) ? 7'd0 : o + 7'd1;
  endfunction

  function automatic logic [6:0] off_dec(input logic [6:0] o);
    return (o == 7'd0) ? 7'd99 : o - 7'd1;
  endfunction

  assign busy = (state == ALIGN);

  // Word, offset, state and the registered done pulse all move together on each edge.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      q      <= '0;
      offset <= '0;
      state  <= IDLE;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            q      <= data;
            offset <= 7'd0;
          end else if (align) begin
            // Already aligned: acknowledge at once without ever raising busy.
            if (offset != 7'd0) state <= ALIGN;
            else                done  <= 1'b1;
          end else begin
            case (ena)
              2'b01: begin
                q      <= rot_right(q);
                offset <= off_inc(offset);
              end
              2'b10: begin
                q      <= rot_left(q);
                offset <= off_dec(offset);
              end
              default: ;
            endcase
          end
        end
        ALIGN: begin
          if (load) begin
            // Abort: the new word defines a fresh alignment, so no done pulse.
            q      <= data;
            offset <= 7'd0;
            state  <= IDLE;
          end else if (offset <= 7'd50) begin
            // Shorter path is leftward; the 50 tie also goes left.
            q      <= rot_left(q);
            offset <= off_dec(offset);
            if (offset == 7'd1) begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end else begin
            q      <= rot_right(q);
            offset <= off_inc(offset);
            if (offset == 7'd99) begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rotate100_realign.sv
// Bench for rotate100_realign: directed scenarios plus randomized traffic against a reference model.
// The model keeps the loaded word and net offset; the expected q is derived from them arithmetically.
// Inputs change 1ns after each rising edge, and outputs are sampled at that same point.
module tb_rotate100_realign;

  logic        clk;
  logic        areset_n;
  logic        load;
  logic [1:0]  ena;
  logic [99:0] data;
  logic        align;
  logic [99:0] q;
  logic [6:0]  offset;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  localparam logic [99:0] D = 100'h1_2345_6789_ABCD_EF01_2345_6789;
  localparam logic [99:0] E = 100'hF_0F0F_1234_5555_AAAA_0000_FFFF;

  // Reference model state
  logic [99:0] m_ld;
  int          m_off;
  bit          m_align;
  bit          m_done;

  rotate100_realign dut (
    .clk      (clk),
    .areset_n (areset_n),
    .load     (load),
    .ena      (ena),
    .data     (data),
    .align    (align),
    .q        (q),
    .offset   (offset),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The current word is always the loaded word rotated right by the net offset.
  function automatic logic [99:0] exp_q();
    logic [99:0] r;
    for (int i = 0; i < 100; i++) r[i] = m_ld[(i + m_off) % 100];
    return r;
  endfunction

  function automatic logic [99:0] rand100();
    logic [127:0] w;
    w = {$urandom, $urandom, $urandom, $urandom};
    return w[99:0];
  endfunction

  task automatic model_reset();
    m_ld = '0; m_off = 0; m_align = 0; m_done = 0;
  endtask

  // Apply one clock edge's worth of behaviour to the model.
  task automatic model_step(input logic l, input logic [1:0] e, input logic [99:0] d, input logic a);
    m_done = 0;
    if (l) begin
      m_ld = d; m_off = 0; m_align = 0;
    end else if (m_align) begin
      if (m_off <= 50) m_off = (m_off + 99) % 100;
      else             m_off = (m_off + 1) % 100;
      if (m_off == 0) begin m_align = 0; m_done = 1; end
    end else if (a) begin
      if (m_off != 0) m_align = 1;
      else            m_done = 1;
    end else if (e == 2'b01) begin
      m_off = (m_off + 1) % 100;
    end else if (e == 2'b10) begin
      m_off = (m_off + 99) % 100;
    end
  endtask

  task automatic cyc(input logic l, input logic [1:0] e, input logic [99:0] d, input logic a);
    load = l; ena = e; data = d; align = a;
    @(posedge clk);
    model_step(l, e, d, a);
    #1;
  endtask

  task automatic test_reset();
    areset_n = 1'b0; load = 0; ena = 0; data = '0; align = 0;
    model_reset();
    #12;
    checks++; if (q !== 100'd0) begin errors++; $display("FAIL reset_q got %h want 0", q); end
    checks++; if (offset !== 7'd0) begin errors++; $display("FAIL reset_offset got %0d want 0", offset); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    @(negedge clk); areset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int exp_off [3] = '{2, 1, 0};
    cyc(1, 2'b00, D, 0);
    for (int i = 0; i < 3; i++) cyc(0, 2'b01, '0, 0);
    checks++; if (offset !== 7'd3 || q !== exp_q()) begin errors++; $display("FAIL basic_rot got off=%0d q=%h want off=3 q=%h", offset, q, exp_q()); end
    cyc(0, 2'b00, '0, 1);
    checks++; if (busy !== 1'b1 || done !== 1'b0 || offset !== 7'd3) begin errors++; $display("FAIL basic_e0 got busy=%b done=%b off=%0d want 1 0 3", busy, done, offset); end
    for (int i = 0; i < 3; i++) begin
      cyc(0, 2'b00, '0, 0);
      checks++;
      if (offset !== 7'(exp_off[i]) || busy !== (i < 2) || done !== (i == 2) || q !== exp_q()) begin
        errors++; $display("FAIL basic_step%0d got off=%0d busy=%b done=%b want off=%0d", i, offset, busy, done, exp_off[i]);
      end
    end
    checks++; if (q !== D) begin errors++; $display("FAIL basic_final_q got %h want %h", q, D); end
    cyc(0, 2'b00, '0, 0);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_clear got %b want 0", done); end
  endtask

  task automatic test_wrap();
    cyc(1, 2'b00, D, 0);
    cyc(0, 2'b10, '0, 0);
    checks++; if (offset !== 7'd99 || q !== exp_q()) begin errors++; $display("FAIL wrap_left got off=%0d want 99", offset); end
    cyc(0, 2'b00, '0, 1);
    cyc(0, 2'b00, '0, 0);
    checks++; if (q !== D || offset !== 7'd0 || done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL wrap_align got off=%0d done=%b busy=%b q=%h", offset, done, busy, q); end
  endtask

  // Align from the given offset and count steps until done; returns step count.
  task automatic run_align(output int n, output int first_off);
    n = 0; first_off = -1;
    cyc(0, 2'b00, '0, 1);
    while (busy && n < 60) begin
      cyc(0, 2'b00, '0, 0);
      n++;
      if (n == 1) first_off = int'(offset);
    end
  endtask

  task automatic test_tie();
    int n, f;
    cyc(1, 2'b00, D, 0);
    for (int i = 0; i < 50; i++) cyc(0, 2'b01, '0, 0);
    checks++; if (offset !== 7'd50) begin errors++; $display("FAIL tie_off got %0d want 50", offset); end
    run_align(n, f);
    checks++; if (n != 50 || f != 49) begin errors++; $display("FAIL tie_steps got n=%0d first=%0d want 50 49", n, f); end
    checks++; if (q !== D || done !== 1'b1) begin errors++; $display("FAIL tie_final got done=%b q=%h", done, q); end
    for (int i = 0; i < 51; i++) cyc(0, 2'b01, '0, 0);
    run_align(n, f);
    checks++; if (n != 49 || f != 52) begin errors++; $display("FAIL tie51_steps got n=%0d first=%0d want 49 52", n, f); end
    checks++; if (q !== D || done !== 1'b1 || offset !== 7'd0) begin errors++; $display("FAIL tie51_final got off=%0d done=%b", offset, done); end
  endtask

  task automatic test_align_zero();
    cyc(1, 2'b00, D, 0);
    cyc(0, 2'b00, '0, 1);
    checks++; if (done !== 1'b1 || busy !== 1'b0 || q !== D) begin errors++; $display("FAIL zero_align got done=%b busy=%b", done, busy); end
    cyc(0, 2'b00, '0, 0);
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL zero_after got done=%b busy=%b want 0 0", done, busy); end
  endtask

  task automatic test_abort_ignore();
    cyc(1, 2'b00, D, 0);
    for (int i = 0; i < 20; i++) cyc(0, 2'b01, '0, 0);
    cyc(0, 2'b00, '0, 1);
    for (int i = 0; i < 5; i++) cyc(0, 2'b01, '0, 1);
    checks++; if (offset !== 7'd15 || busy !== 1'b1 || q !== exp_q()) begin errors++; $display("FAIL ignore_ena got off=%0d busy=%b want 15 1", offset, busy); end
    cyc(1, 2'b00, E, 0);
    checks++; if (q !== E || offset !== 7'd0 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL abort got off=%0d busy=%b done=%b q=%h", offset, busy, done, q); end
    cyc(0, 2'b00, '0, 0);
    checks++; if (done !== 1'b0 || q !== E) begin errors++; $display("FAIL abort_after got done=%b want 0", done); end
  endtask

  task automatic test_back_to_back();
    cyc(1, 2'b00, D, 0);
    cyc(0, 2'b01, '0, 0);
    cyc(0, 2'b01, '0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 2'b00, '0, 1);
    checks++; if (done !== 1'b1 || offset !== 7'd0) begin errors++; $display("FAIL b2b_first got done=%b off=%0d", done, offset); end
    cyc(0, 2'b00, '0, 1);
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL b2b_resample got done=%b busy=%b want 1 0", done, busy); end
    cyc(0, 2'b00, '0, 0);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b_clear got done=%b want 0", done); end
  endtask

  task automatic test_async_reset();
    cyc(1, 2'b00, D, 0);
    for (int i = 0; i < 30; i++) cyc(0, 2'b01, '0, 0);
    cyc(0, 2'b00, '0, 1);
    for (int i = 0; i < 5; i++) cyc(0, 2'b00, '0, 0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL areset_pre busy=%b want 1", busy); end
    #2 areset_n = 1'b0;
    model_reset();
    #1;
    checks++; if (q !== 100'd0 || offset !== 7'd0 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL areset_now got off=%0d busy=%b done=%b q=%h", offset, busy, done, q); end
    @(negedge clk); areset_n = 1'b1;
    cyc(0, 2'b11, '0, 0);
    cyc(0, 2'b11, '0, 0);
    checks++; if (q !== 100'd0 || offset !== 7'd0) begin errors++; $display("FAIL areset_hold got off=%0d q=%h", offset, q); end
  endtask

  task automatic test_random();
    int r;
    logic l, a;
    logic [1:0] e;
    for (int c = 0; c < 2000; c++) begin
      r = $urandom_range(0, 99);
      l = (r < 3);
      a = (r >= 3 && r < 10);
      e = 2'($urandom_range(0, 3));
      cyc(l, e, rand100(), a);
      checks++;
      if (q !== exp_q() || offset !== 7'(m_off) || busy !== m_align || done !== m_done) begin
        errors++;
        $display("FAIL random_c%0d got off=%0d busy=%b done=%b want off=%0d busy=%b done=%b", c, offset, busy, done, m_off, m_align, m_done);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_tie();
    test_align_zero();
    test_abort_ignore();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
